// File: rtl/mem_arbiter_if.sv
// Purpose : bundle of CPU, peripheral and RAM-side signals seen by mem_arbiter.
// Latency : n/a (wiring only).
// Backpressure: requesters hold *_req until their *_gnt; read data returns on *_rvalid.
// Ports   : slave modport = arbiter view, master modport = requesters/RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  // Peripheral (read-only) port
  logic              per_req;
  logic [ADDR_W-1:0] per_addr;
  logic              per_gnt;
  logic              per_rvalid;
  logic [DATA_W-1:0] per_rdata;
  // RAM port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, per_req, per_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, per_gnt, per_rvalid, per_rdata,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, per_req, per_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, per_gnt, per_rvalid, per_rdata,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port RAM between the CPU (fixed priority) and a
//           read-only peripheral, with an anti-starvation wait counter.
// Latency : grant combinational in the request cycle; read data one cycle after grant.
// Backpressure: a losing requester keeps its request up; the peripheral is
//           guaranteed a grant within MAX_WAIT+1 contention cycles.
// Ports   : clk (rising edge), reset (sync, active low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              per_rvalid_q, per_rvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cpu_gnt, per_gnt;

  // Arbitration: peripheral wins when alone or once it has been denied
  // MAX_WAIT consecutive cycles; otherwise the CPU wins.
  always_comb begin
    cpu_gnt = 1'b0;
    per_gnt = 1'b0;
    if (reset) begin
      if (bus.per_req && (!bus.cpu_req || wait_cnt_q == MAX_CNT)) begin
        per_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (reset && bus.per_req && !per_gnt) begin
      wait_cnt_d = (wait_cnt_q == MAX_CNT) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
    // Grants are already forced low during reset, so these clear too.
    cpu_rvalid_d = cpu_gnt & ~bus.cpu_we;
    per_rvalid_d = per_gnt;
    // Remember the last granted address so mem_addr is stable when idle.
    addr_d = addr_q;
    if (cpu_gnt) begin
      addr_d = bus.cpu_addr;
    end else if (per_gnt) begin
      addr_d = bus.per_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      per_rvalid_q <= 1'b0;
      addr_q       <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      per_rvalid_q <= per_rvalid_d;
      addr_q       <= addr_d;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.per_gnt   = per_gnt;
  assign bus.mem_we    = cpu_gnt & bus.cpu_we;
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr :
                         per_gnt ? bus.per_addr : addr_q;

  // A read in flight when reset drops is discarded: rvalid is masked while
  // reset is low and the pipeline register clears at the reset edge.
  assign bus.cpu_rvalid = cpu_rvalid_q & reset;
  assign bus.per_rvalid = per_rvalid_q & reset;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.per_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : scoreboard bench for mem_arbiter with a behavioural RAM and reference model.
// Latency : expects grants in the request cycle and read data one cycle later.
// Backpressure: requesters hold requests until granted, as a real master would.
module tb_mem_arbiter;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- behavioural RAM (registered read) ----------------
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // ---------------- reference model state ----------------
  typedef struct {
    logic        who;   // 0 = cpu, 1 = peripheral
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] shadow [logic [15:0]];
  int          denied = 0;
  logic [15:0] last_addr;
  bit          have_last = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          log_en = 0;
  string       glog = "";
  logic        last_cg = 0, last_pg = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decides from the arbitration rules who must win this
  // cycle, checks the RAM-side outputs and queues the expected read returns.
  always @(negedge clk) begin
    logic        ep, ec;
    logic [15:0] ea;
    if (!reset) begin
      check("rst_cpu_gnt", bus.cpu_gnt, 0);
      check("rst_per_gnt", bus.per_gnt, 0);
      check("rst_mem_we", bus.mem_we, 0);
      q.delete();
      denied    = 0;
      have_last = 0;
    end else begin
      ep = bus.per_req && (!bus.cpu_req || denied == MAXW);
      ec = bus.cpu_req && !ep;
      check("wait_cnt", 32'(dut.wait_cnt_q), 32'(denied));
      check("cpu_gnt", bus.cpu_gnt, ec);
      check("per_gnt", bus.per_gnt, ep);
      check("mem_we", bus.mem_we, ec && bus.cpu_we);
      if (ec || ep) begin
        ea = ec ? bus.cpu_addr : bus.per_addr;
        check("mem_addr", bus.mem_addr, ea);
        last_addr = ea;
        have_last = 1;
      end else if (have_last) begin
        check("mem_addr_hold", bus.mem_addr, last_addr);
      end
      if (ec && bus.cpu_we) begin
        check("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
        shadow[bus.cpu_addr] = bus.cpu_wdata;
      end
      if (ec && !bus.cpu_we) q.push_back('{who: 1'b0, data: model_rd(bus.cpu_addr), due: cyc + 1});
      if (ep) q.push_back('{who: 1'b1, data: model_rd(bus.per_addr), due: cyc + 1});
      if (log_en && ec) glog = {glog, "C"};
      if (log_en && ep) glog = {glog, "P"};
      if (bus.per_req && !ep) denied = (denied < MAXW) ? denied + 1 : MAXW;
      else denied = 0;
    end
  end

  // Monitor: pops the scoreboard whenever a read return is due or presented.
  always @(negedge clk) begin
    logic exp_c, exp_p;
    #1;
    while (q.size() > 0 && q[0].due < cyc) begin
      check("rvalid_missing", 0, 1);
      void'(q.pop_front());
    end
    exp_c = q.size() > 0 && q[0].due == cyc && q[0].who == 1'b0;
    exp_p = q.size() > 0 && q[0].due == cyc && q[0].who == 1'b1;
    check("cpu_rvalid", bus.cpu_rvalid, exp_c);
    check("per_rvalid", bus.per_rvalid, exp_p);
    check("both_rvalid", bus.cpu_rvalid & bus.per_rvalid, 0);
    if (exp_c && bus.cpu_rvalid) check("cpu_rdata", bus.cpu_rdata, q[0].data);
    if (exp_p && bus.per_rvalid) check("per_rdata", bus.per_rdata, q[0].data);
    if (exp_c || exp_p) void'(q.pop_front());
  end

  // Applies one cycle of stimulus, records the grants seen in that cycle.
  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [15:0] cd, input logic pr, input logic [15:0] pa);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.per_req   = pr;
    bus.per_addr  = pa;
    @(negedge clk);
    last_cg = bus.cpu_gnt;
    last_pg = bus.per_gnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        cr, cw, pr;
    logic [15:0] ca, cd, pa;
    for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
    ram[16'h0100]    = 16'h1234;
    shadow[16'h0100] = 16'h1234;

    // Reset held for two cycles with both requesters active.
    reset = 1'b0;
    drive(1, 0, 16'h0001, 16'h0, 1, 16'h0002);
    drive(1, 0, 16'h0001, 16'h0, 1, 16'h0002);
    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Solo CPU write then read-back.
    drive(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0);
    drive(1, 0, 16'h0010, 16'h0, 0, 16'h0);
    drive(0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Solo peripheral read.
    drive(0, 0, 16'h0, 16'h0, 1, 16'h0100);
    drive(0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Sustained contention must give CCCCP repeating.
    log_en = 1;
    for (int i = 0; i < 15; i++) drive(1, 0, 16'h0020, 16'h0, 1, 16'h0030);
    log_en = 0;
    checks++;
    if (glog != "CCCCPCCCCPCCCCP") begin
      failures++;
      $display("FAIL contention_pattern: got %s expected CCCCPCCCCPCCCCP", glog);
    end
    drive(0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Back-to-back alternating single-cycle requests.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 16'h0002, 16'h0, 0, 16'h0);
      drive(0, 0, 16'h0, 16'h0, 1, 16'h0003);
    end
    drive(0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Reset arriving while a CPU read is in flight.
    drive(1, 0, 16'h0005, 16'h0, 0, 16'h0);
    reset = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 0, 16'h0);
    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Randomised traffic with request-until-grant handshaking.
    cr = 0; cw = 0; ca = 0; cd = 0; pr = 0; pa = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!cr || last_cg) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = 1'($urandom_range(0, 1));
        ca = 16'($urandom_range(0, 15));
        cd = 16'($urandom);
      end
      if (!pr || last_pg) begin
        pr = ($urandom_range(0, 2) != 0);
        pa = 16'($urandom_range(0, 15));
      end
      drive(cr, cw, ca, cd, pr, pa);
    end

    for (int i = 0; i < 3; i++) drive(0, 0, 16'h0, 16'h0, 0, 16'h0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
